text_row_fetcher: RTL and testbench
===================================

Name: text_row_fetcher

Overview:
- Apple II 40x24 text-mode row fetcher, directly upstream of the character generator.
- Reads each text row's 40 character codes from video memory during horizontal blanking, using a req/ack handshake, into a ping-pong line buffer.
- During active display, presents the character code for the current Apple pixel coordinate, plus pipeline-aligned coordinates.
- Isolates the character generator from memory arbitration latency.

Parameters:
- BASE_PAGE1, 16'h0400, text page 1 base address
- BASE_PAGE2, 16'h0800, text page 2 base address
- COLS, 40, characters per row
- ROWS, 24, text rows per frame (must be even)
- FILL_CHAR, 8'hA0, code substituted on underrun/abort (normal space)
- TIMEOUT_CYCLES, 64, ack watchdog limit (optional feature only)

Ports:
- clkVGA  in  1  pixel/VGA clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- xPos  in  10  Apple pixel column 0..279 (valid when active=1)
- yPos  in  10  Apple scanline 0..191
- active  in  1  input coordinate is inside the 280x192 window
- hblankStart  in  1  one-cycle pulse at start of horizontal blanking, after the line given by yPos
- page2  in  1  selects BASE_PAGE2; sampled at fetch start
- memReq  out  1  memory read request
- memAddr  out  16  read address; held stable while memReq=1
- memAck  in  1  read complete; memData valid in the same cycle
- memData  in  8  character byte
- charApple  out  8  character code for the character generator
- xPosOut  out  10  xPos delayed to align with charApple
- yPosOut  out  10  yPos delayed to align with charApple
- activeOut  out  1  active delayed to align with charApple
- underrun  out  1  sticky: a display row was needed before its fetch completed

Behaviour:
- Reset (async, rst=1): every output is 0 (memAddr=0, charApple=0, underrun=0); both banks are marked invalid; FSM enters IDLE.
- On the first cycle after reset deassertion, the FSM automatically launches a fetch of row 0.
- Address rule: memAddr = base + (row[2:0] << 7) + (row[4:3] * 40) + col, computed in 16 bits. This is the interleaved Apple layout.
- Bank selection: row r is written to bank r[0]; display reads bank (yPos>>3)[0]. Each bank is COLS x 8 bits with a valid flag.
- Fetch triggers on hblankStart:
  - yPos[2:0]==7 and yPos<191 -> fetch row (yPos>>3)+1.
  - yPos==191 -> fetch row 0 for the next frame.
  - Otherwise no fetch.
- A trigger while the FSM is not IDLE is ignored and sets underrun.
- FSM states:
  - IDLE: wait for a trigger. On trigger, latch row and page2, clear the target bank's valid flag, col=0, go to REQ.
  - REQ: memReq=1 with the current address. On memAck: write memData to bank[col]. If col==COLS-1, go to DONE; else col++ and stay in REQ. memAddr updates in the cycle after the ack.
  - DONE: set the bank's valid flag, drop memReq, return to IDLE (1 cycle).
- memReq stays high continuously across the 40 reads. The memory side may ack in the same cycle memReq first rises.
- Display path, one-cycle registered latency:
  - charApple <= bank[yPos>>3 parity][xPos/7] when active=1 and that bank is valid.
  - When active=1 but the bank is invalid: charApple <= FILL_CHAR and underrun <= 1.
  - When active=0: charApple <= FILL_CHAR.
  - xPos/7 uses a constant divide or a 280-entry-free counter method; result range 0..39.
- xPosOut, yPosOut and activeOut are registered in the same cycle as charApple (latency 1).
- underrun clears only on rst.
- Reset mid-fetch: memReq drops asynchronously, the partial bank stays invalid, and the fetch restarts from row 0.

Optional Feature:
- Macro: TEXT_FETCH_TIMEOUT_EN.
- When defined: a counter runs while in REQ, cleared on each memAck. On reaching TIMEOUT_CYCLES, the FSM fills the remaining columns with FILL_CHAR at 1 col/cycle (memReq=0), marks the bank valid, and sets underrun.
- When undefined: REQ waits indefinitely for memAck.

Decomposition:
- Shared package apple_text_pkg: BASE_PAGE1/2, COLS, ROWS, FILL_CHAR, fetch state enum (IDLE, REQ, FILL, DONE), row-address function.
- One natural sub-module: text_line_buffer. It holds the 2 banks x COLS x 8 bits and the valid flags, with one write port and one registered read port.

Test Plan:
- Reset release, page2=0, memAck one cycle after each memReq -> addresses 0x0400..0x0427 in order; bank0 becomes valid after 40 acks plus 1 DONE cycle.
- Row 9 fetch (trigger at yPos=71), page2=1 -> first memAddr = 0x0800+0x080+0x28 = 0x08A8; last = 0x08CF.
- Bank0 filled with bytes 0xC1+col, active scan at yPos=0 -> charApple=0xC1 one cycle after xPos=0..6, 0xC2 for xPos=7..13; xPosOut equals the previous-cycle xPos.
- memAck withheld so the fetch is not done when yPos reaches 8 -> charApple=0xA0 across the row and underrun=1 thereafter.
- hblankStart at yPos=191 -> row 0 refetched; a second trigger during the fetch is ignored and sets underrun.
- TEXT_FETCH_TIMEOUT_EN defined, memAck stops after col 5 -> after 64 cycles columns 6..39 read 0xA0, the bank is valid, underrun=1, and memReq=0 during fill.

Source files
------------

// File: rtl/apple_text_pkg.sv
// Shared constants, fetch FSM state type and the interleaved Apple II text
// row address helper used by the text row fetcher.
package apple_text_pkg;

  localparam logic [15:0] BASE_PAGE1     = 16'h0400;
  localparam logic [15:0] BASE_PAGE2     = 16'h0800;
  localparam int unsigned COLS           = 40;
  localparam int unsigned ROWS           = 24;
  localparam logic [7:0]  FILL_CHAR      = 8'hA0;
  localparam int unsigned TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {StIdle, StReq, StFill, StDone} fetch_state_e;

  // Apple text memory is interleaved: row[2:0] selects a 128-byte block,
  // row[4:3] selects one of three 40-byte thirds inside that block.
  function automatic logic [15:0] row_addr(input logic [4:0] row, input logic [5:0] col,
                                           input logic page2);
    logic [15:0] base;
    base = page2 ? BASE_PAGE2 : BASE_PAGE1;
    return base + {6'd0, row[2:0], 7'd0} + (16'(row[4:3]) * 16'd40) + {10'd0, col};
  endfunction

endpackage

// File: rtl/text_row_fetcher_if.sv
// Memory read bus of the text row fetcher.
//   memReq  : read request, held high across a whole row
//   memAddr : read address, stable while memReq=1
//   memAck  : read complete, memData valid in the same cycle
//   memData : character byte
interface text_row_fetcher_if;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memAck;
  logic [7:0]  memData;

  modport master (output memReq, memAddr, input memAck, memData);
  modport slave  (input memReq, memAddr, output memAck, memData);
endinterface

// File: rtl/text_line_buffer.sv
// Ping-pong line buffer: 2 banks x COLS bytes, one valid flag per bank.
//   clk, rst          : clock, async active-high reset (clears flags and read register)
//   clr_en/clr_bank   : invalidate a bank when its fetch starts
//   set_en/set_bank   : mark a bank valid when its fetch completes
//   wr_en/bank/col/data : write port
//   rd_en/bank/col    : registered read port; rd_data is FILL_CHAR when not
//                       enabled, bank invalid or column out of range
//   valid             : current bank valid flags
module text_line_buffer
  import apple_text_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_en,
  input  logic       clr_bank,
  input  logic       set_en,
  input  logic       set_bank,
  input  logic       wr_en,
  input  logic       wr_bank,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic       rd_bank,
  input  logic [5:0] rd_col,
  output logic [1:0] valid,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [2][COLS];
  logic [1:0] valid_q, valid_d;
  logic [7:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank][wr_col] <= wr_data;
  end

  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_bank] = 1'b0;
    if (set_en) valid_d[set_bank] = 1'b1;
  end

  always_comb begin
    rd_data_d = FILL_CHAR;
    if (rd_en && valid_q[rd_bank] && (32'(rd_col) < COLS)) rd_data_d = mem_q[rd_bank][rd_col];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 2'b00;
      rd_data_q <= 8'h00;
    end else begin
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign valid   = valid_q;
  assign rd_data = rd_data_q;

endmodule

// File: rtl/text_row_fetcher.sv
// Apple II 40x24 text row fetcher. Pulls each text row from video memory
// during horizontal blanking into a ping-pong line buffer and serves the
// character code for the current pixel with one cycle of latency.
//   clkVGA, rst        : clock, async active-high reset
//   xPos, yPos, active : Apple pixel coordinate and in-window flag
//   hblankStart        : fetch trigger pulse, after the line given by yPos
//   page2              : text page select, sampled at fetch start
//   mem                : memory read bus (master)
//   charApple          : character code for the character generator
//   xPosOut, yPosOut, activeOut : coordinates aligned with charApple
//   underrun           : sticky fetch-too-late / overlap / timeout flag
// Build option: define TEXT_FETCH_TIMEOUT_EN to add an ack watchdog that
// fills the rest of a stalled row with FILL_CHAR.
module text_row_fetcher
  import apple_text_pkg::*;
(
  input  logic               clkVGA,
  input  logic               rst,
  input  logic [9:0]         xPos,
  input  logic [9:0]         yPos,
  input  logic               active,
  input  logic               hblankStart,
  input  logic               page2,
  text_row_fetcher_if.master mem,
  output logic [7:0]         charApple,
  output logic [9:0]         xPosOut,
  output logic [9:0]         yPosOut,
  output logic               activeOut,
  output logic               underrun
);

  localparam logic [5:0] LastCol = 6'(COLS - 1);

  fetch_state_e state_q, state_d;
  logic [4:0]   row_q, row_d;
  logic         page2_q, page2_d;
  logic [5:0]   col_q, col_d;
  logic         start_q, start_d;
  logic         underrun_q, underrun_d;
  logic [9:0]   xpos_q, ypos_q;
  logic         active_q;

  logic         trig_hit;
  logic [4:0]   trig_row;
  logic         launch;
  logic [4:0]   launch_row;
  logic         busy_trig;
  logic         timeout_hit;
  logic         req;
  logic         wr_en;
  logic [7:0]   wr_data;
  logic         set_en;
  logic [1:0]   bank_valid;
  logic         rd_bank;
  logic [5:0]   rd_col;

  // yPos=191 also has [2:0]=7, so one compare covers both trigger cases.
  assign trig_hit = hblankStart && (yPos[2:0] == 3'd7) && (yPos <= 10'd191);
  assign trig_row = (yPos == 10'd191) ? 5'd0 : yPos[7:3] + 5'd1;

`ifdef TEXT_FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cnt_expired;

  assign cnt_expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == StReq && !mem.memAck) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clkVGA or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    page2_d     = page2_q;
    col_d       = col_q;
    start_d     = start_q;
    launch      = 1'b0;
    launch_row  = 5'd0;
    set_en      = 1'b0;
    wr_en       = 1'b0;
    wr_data     = mem.memData;
    req         = 1'b0;
    busy_trig   = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        // start_q forces the row-0 fetch right after reset.
        if (start_q || trig_hit) begin
          launch     = 1'b1;
          launch_row = start_q ? 5'd0 : trig_row;
          start_d    = 1'b0;
          row_d      = launch_row;
          page2_d    = page2;
          col_d      = 6'd0;
          state_d    = StReq;
        end
      end
      StReq: begin
        req = 1'b1;
        if (mem.memAck) begin
          wr_en = 1'b1;
          if (col_q == LastCol) state_d = StDone;
          else                  col_d   = col_q + 6'd1;
        end
`ifdef TEXT_FETCH_TIMEOUT_EN
        else if (cnt_expired) begin
          timeout_hit = 1'b1;
          state_d     = StFill;
        end
`endif
      end
`ifdef TEXT_FETCH_TIMEOUT_EN
      StFill: begin
        wr_en   = 1'b1;
        wr_data = FILL_CHAR;
        if (col_q == LastCol) state_d = StDone;
        else                  col_d   = col_q + 6'd1;
      end
`endif
      StDone: begin
        set_en  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle && trig_hit) busy_trig = 1'b1;
  end

  assign rd_bank = yPos[3];
  assign rd_col  = 6'(xPos / 10'd7);

  assign underrun_d = underrun_q | busy_trig | timeout_hit | (active & ~bank_valid[rd_bank]);

  always_ff @(posedge clkVGA or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= 5'd0;
      page2_q    <= 1'b0;
      col_q      <= 6'd0;
      start_q    <= 1'b1;
      underrun_q <= 1'b0;
      xpos_q     <= 10'd0;
      ypos_q     <= 10'd0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      page2_q    <= page2_d;
      col_q      <= col_d;
      start_q    <= start_d;
      underrun_q <= underrun_d;
      xpos_q     <= xPos;
      ypos_q     <= yPos;
      active_q   <= active;
    end
  end

  // req comes straight from the async-reset state, so it drops with rst.
  assign mem.memReq  = req;
  assign mem.memAddr = req ? row_addr(row_q, col_q, page2_q) : 16'h0000;

  text_line_buffer u_line_buffer (
    .clk      (clkVGA),
    .rst      (rst),
    .clr_en   (launch),
    .clr_bank (launch_row[0]),
    .set_en   (set_en),
    .set_bank (row_q[0]),
    .wr_en    (wr_en),
    .wr_bank  (row_q[0]),
    .wr_col   (col_q),
    .wr_data  (wr_data),
    .rd_en    (active),
    .rd_bank  (rd_bank),
    .rd_col   (rd_col),
    .valid    (bank_valid),
    .rd_data  (charApple)
  );

  assign xPosOut   = xpos_q;
  assign yPosOut   = ypos_q;
  assign activeOut = active_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_text_row_fetcher.sv
// Directed bench for text_row_fetcher: row fetch addressing, page select,
// display path, frame wrap, overlap, mid-fetch reset and underrun.
module tb_text_row_fetcher;

  logic       clkVGA = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] xPos = 10'd0;
  logic [9:0] yPos = 10'd0;
  logic       active = 1'b0;
  logic       hblankStart = 1'b0;
  logic       page2 = 1'b0;
  logic [7:0] charApple;
  logic [9:0] xPosOut, yPosOut;
  logic       activeOut, underrun;

  int total = 0;
  int bad   = 0;

  text_row_fetcher_if mif ();

  text_row_fetcher dut (
    .clkVGA      (clkVGA),
    .rst         (rst),
    .xPos        (xPos),
    .yPos        (yPos),
    .active      (active),
    .hblankStart (hblankStart),
    .page2       (page2),
    .mem         (mif),
    .charApple   (charApple),
    .xPosOut     (xPosOut),
    .yPosOut     (yPosOut),
    .activeOut   (activeOut),
    .underrun    (underrun)
  );

  always #5 clkVGA = ~clkVGA;

  // Memory responder: ack one cycle after each request is seen, checking the
  // address of every read against base+col.
  task automatic serve(input logic [15:0] base, input logic [7:0] d0, input int first,
                       input int n);
    for (int c = first; c < first + n; c++) begin
      int w;
      w = 0;
      while (mif.memReq !== 1'b1 && w < 50) begin
        @(negedge clkVGA);
        w++;
      end
      total++;
      if (mif.memReq !== 1'b1 || mif.memAddr !== base + 16'(c)) begin
        $display("FAIL mem_addr col=%0d: got req=%b addr=%h, want req=1 addr=%h", c,
                 mif.memReq, mif.memAddr, base + 16'(c));
        bad++;
      end
      @(negedge clkVGA);
      mif.memAck  = 1'b1;
      mif.memData = d0 + 8'(c);
      @(negedge clkVGA);
      mif.memAck  = 1'b0;
    end
  endtask

  task automatic pulse(input logic [9:0] y, input logic p2);
    yPos = y;
    page2 = p2;
    hblankStart = 1'b1;
    @(negedge clkVGA);
    hblankStart = 1'b0;
    page2 = 1'b0;
  endtask

  task automatic look(input logic [9:0] x, input logic [9:0] y, input logic a);
    xPos = x;
    yPos = y;
    active = a;
    @(negedge clkVGA);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clkVGA);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (mif.memReq !== 1'b0 || mif.memAddr !== 16'h0 || charApple !== 8'h00 ||
        underrun !== 1'b0 || xPosOut !== 10'd0 || yPosOut !== 10'd0 || activeOut !== 1'b0) begin
      $display("FAIL reset: got req=%b addr=%h char=%h und=%b x=%0d y=%0d act=%b, want all 0",
               mif.memReq, mif.memAddr, charApple, underrun, xPosOut, yPosOut, activeOut);
      bad++;
    end
    @(negedge clkVGA);
    rst = 1'b0;
  endtask

  task automatic test_initial_fetch();
    serve(16'h0400, 8'hC1, 0, 40);
    total++;
    if (mif.memReq !== 1'b0) begin
      $display("FAIL done_req: got %b want 0", mif.memReq);
      bad++;
    end
    @(negedge clkVGA);
  endtask

  task automatic test_display();
    logic [9:0] xs [6];
    logic [7:0] ex [6];
    xs = '{10'd0, 10'd6, 10'd7, 10'd13, 10'd14, 10'd279};
    ex = '{8'hC1, 8'hC1, 8'hC2, 8'hC2, 8'hC3, 8'hE8};
    for (int i = 0; i < 6; i++) begin
      look(xs[i], 10'd0, 1'b1);
      total++;
      if (charApple !== ex[i] || xPosOut !== xs[i] || activeOut !== 1'b1 ||
          yPosOut !== 10'd0) begin
        $display("FAIL display x=%0d: got char=%h xo=%0d act=%b yo=%0d, want %h %0d 1 0",
                 xs[i], charApple, xPosOut, activeOut, yPosOut, ex[i], xs[i]);
        bad++;
      end
    end
    look(10'd0, 10'd0, 1'b0);
    total++;
    if (charApple !== 8'hA0 || activeOut !== 1'b0 || underrun !== 1'b0) begin
      $display("FAIL inactive: got char=%h act=%b und=%b, want a0 0 0",
               charApple, activeOut, underrun);
      bad++;
    end
  endtask

  task automatic test_row9_page2();
    pulse(10'd71, 1'b1);
    serve(16'h08A8, 8'h10, 0, 40);
    @(negedge clkVGA);
    look(10'd0, 10'd72, 1'b1);
    total++;
    if (charApple !== 8'h10) begin
      $display("FAIL row9_first: got %h want 10", charApple);
      bad++;
    end
    look(10'd279, 10'd72, 1'b1);
    total++;
    if (charApple !== 8'h37 || underrun !== 1'b0) begin
      $display("FAIL row9_last: got char=%h und=%b want 37 0", charApple, underrun);
      bad++;
    end
    look(10'd8, 10'd0, 1'b1);
    total++;
    if (charApple !== 8'hC2) begin
      $display("FAIL bank0_kept: got %h want c2", charApple);
      bad++;
    end
    look(10'd0, 10'd0, 1'b0);
  endtask

  task automatic test_wrap_overlap();
    pulse(10'd191, 1'b0);
    serve(16'h0400, 8'h60, 0, 5);
    total++;
    if (underrun !== 1'b0) begin
      $display("FAIL pre_overlap: got und=%b want 0", underrun);
      bad++;
    end
    pulse(10'd71, 1'b1);
    total++;
    if (underrun !== 1'b1) begin
      $display("FAIL overlap_und: got und=%b want 1", underrun);
      bad++;
    end
    serve(16'h0400, 8'h60, 5, 35);
    @(negedge clkVGA);
    look(10'd0, 10'd0, 1'b1);
    total++;
    if (charApple !== 8'h60) begin
      $display("FAIL wrap_first: got %h want 60", charApple);
      bad++;
    end
    look(10'd279, 10'd0, 1'b1);
    total++;
    if (charApple !== 8'h87) begin
      $display("FAIL wrap_last: got %h want 87", charApple);
      bad++;
    end
    look(10'd0, 10'd0, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    pulse(10'd7, 1'b0);
    serve(16'h0480, 8'h00, 0, 3);
    rst = 1'b1;
    #1;
    total++;
    if (mif.memReq !== 1'b0 || mif.memAddr !== 16'h0 || underrun !== 1'b0 ||
        charApple !== 8'h00) begin
      $display("FAIL mid_reset: got req=%b addr=%h und=%b char=%h, want 0 0 0 0",
               mif.memReq, mif.memAddr, underrun, charApple);
      bad++;
    end
    @(negedge clkVGA);
    @(negedge clkVGA);
    rst = 1'b0;
    serve(16'h0400, 8'hC1, 0, 40);
    @(negedge clkVGA);
    look(10'd0, 10'd8, 1'b1);
    total++;
    if (charApple !== 8'hA0 || underrun !== 1'b1) begin
      $display("FAIL partial_invalid: got char=%h und=%b want a0 1", charApple, underrun);
      bad++;
    end
    look(10'd0, 10'd0, 1'b0);
  endtask

  task automatic test_underrun();
    do_reset();
    serve(16'h0400, 8'hC1, 0, 40);
    @(negedge clkVGA);
    pulse(10'd7, 1'b0);
    @(negedge clkVGA);
    total++;
    if (underrun !== 1'b0 || mif.memReq !== 1'b1) begin
      $display("FAIL und_start: got und=%b req=%b want 0 1", underrun, mif.memReq);
      bad++;
    end
    look(10'd0, 10'd8, 1'b1);
    total++;
    if (charApple !== 8'hA0 || underrun !== 1'b1) begin
      $display("FAIL und_hit: got char=%h und=%b want a0 1", charApple, underrun);
      bad++;
    end
    look(10'd140, 10'd8, 1'b1);
    total++;
    if (charApple !== 8'hA0) begin
      $display("FAIL und_mid: got %h want a0", charApple);
      bad++;
    end
    look(10'd0, 10'd8, 1'b0);
    serve(16'h0480, 8'h50, 0, 40);
    @(negedge clkVGA);
    look(10'd7, 10'd8, 1'b1);
    total++;
    if (charApple !== 8'h51 || underrun !== 1'b1) begin
      $display("FAIL und_sticky: got char=%h und=%b want 51 1", charApple, underrun);
      bad++;
    end
    look(10'd0, 10'd0, 1'b0);
  endtask

`ifdef TEXT_FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    serve(16'h0400, 8'hC1, 0, 40);
    @(negedge clkVGA);
    pulse(10'd7, 1'b0);
    serve(16'h0480, 8'h50, 0, 6);
    n = 0;
    while (mif.memReq === 1'b1 && n < 200) begin
      n++;
      @(negedge clkVGA);
    end
    total++;
    if (n != 64) begin
      $display("FAIL timeout_len: got %0d cycles want 64", n);
      bad++;
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (mif.memReq !== 1'b0) begin
        $display("FAIL fill_req: got %b want 0", mif.memReq);
        bad++;
      end
      @(negedge clkVGA);
    end
    repeat (40) @(negedge clkVGA);
    look(10'd35, 10'd8, 1'b1);
    total++;
    if (charApple !== 8'h55 || underrun !== 1'b1) begin
      $display("FAIL timeout_col5: got char=%h und=%b want 55 1", charApple, underrun);
      bad++;
    end
    look(10'd42, 10'd8, 1'b1);
    total++;
    if (charApple !== 8'hA0) begin
      $display("FAIL timeout_col6: got %h want a0", charApple);
      bad++;
    end
    look(10'd279, 10'd8, 1'b1);
    total++;
    if (charApple !== 8'hA0) begin
      $display("FAIL timeout_col39: got %h want a0", charApple);
      bad++;
    end
    look(10'd0, 10'd0, 1'b0);
  endtask
`endif

  initial begin
    mif.memAck  = 1'b0;
    mif.memData = 8'h00;
    test_reset();
    test_initial_fetch();
    test_display();
    test_row9_page2();
    test_wrap_overlap();
    test_reset_mid_fetch();
    test_underrun();
`ifdef TEXT_FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
